// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter that funnels NUM_REQ byte streams into one UART TX port.
// A granted requester that goes quiet for TO_CYC cycles mid-packet is aborted and reported.
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int TO_CYC  = 1000,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arb_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [IDW-1:0]          gnt_id,
  output logic                    err_to,
  output logic [IDW-1:0]          err_src
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [15:0] STALL_MAX = 16'(TO_CYC - 1);

  state_t         state_reg, state_next;
  logic [IDW-1:0] gnt_id_reg, gnt_id_next;
  logic [15:0]    stall_reg, stall_next;
  logic           err_to_reg, err_to_next;
  logic [IDW-1:0] err_src_reg, err_src_next;

  logic           xfer_ok;
  logic           cur_valid;
  logic           cur_last;
  logic           handshake;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  int             cand;

  // Outputs are forced quiet while reset is held, even if the state register is still XFER.
  assign xfer_ok   = (state_reg == XFER) && rst_n;
  assign cur_valid = req_valid[gnt_id_reg];
  assign cur_last  = req_last[gnt_id_reg];
  assign tx_valid  = xfer_ok && cur_valid;
  assign tx_data   = req_data[gnt_id_reg];
  assign handshake = tx_valid && tx_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer_ok && (gnt_id_reg == IDW'(gi)) && tx_ready;
    end
  endgenerate

  // Search starts just after the last grant, so the previous winner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(gnt_id_reg) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_id_next  = gnt_id_reg;
    stall_next   = stall_reg;
    err_to_next  = 1'b0;
    err_src_next = err_src_reg;
    case (state_reg)
      IDLE: begin
        if (arb_en && win_found) begin
          state_next  = XFER;
          gnt_id_next = win_idx;
          stall_next  = '0;
        end
      end
      XFER: begin
        if (handshake) begin
          stall_next = '0;
          if (cur_last) state_next = IDLE;
        end else if (!cur_valid) begin
          // Backpressure (valid high, ready low) never counts toward the timeout.
          if (stall_reg == STALL_MAX) begin
            state_next   = IDLE;
            err_to_next  = 1'b1;
            err_src_next = gnt_id_reg;
            stall_next   = '0;
          end else begin
            stall_next = stall_reg + 16'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_id_reg  <= IDW'(NUM_REQ - 1);
      stall_reg   <= '0;
      err_to_reg  <= 1'b0;
      err_src_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_id_reg  <= gnt_id_next;
      stall_reg   <= stall_next;
      err_to_reg  <= err_to_next;
      err_src_reg <= err_src_next;
    end
  end

  assign busy    = (state_reg == XFER);
  assign gnt_id  = gnt_id_reg;
  assign err_to  = err_to_reg;
  assign err_src = err_src_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic, all checked each cycle
// against a packet-level reference model of the arbiter.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int BUF = 1024;

  logic            clk;
  logic            rst_n;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic            busy;
  logic [1:0]      gnt_id;
  logic            err_to;
  logic [1:0]      err_src;

  uart_tx_arb #(.NUM_REQ(N), .TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .gnt_id(gnt_id),
    .err_to(err_to), .err_src(err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Per-requester packet sources: byte/last FIFOs with a hold-off and random-drop control.
  logic [7:0] bd [N][BUF];
  bit         bl [N][BUF];
  int         head [N];
  int         tail [N];
  int         drop_cnt [N];
  bit         hold_off [N];

  // Reference model: whether a packet is open, who owns it, and how long it has starved.
  bit         m_ok = 1'b0;
  bit         m_busy;
  int         m_gnt;
  int         m_starve;
  bit         m_err_to;
  int         m_err_src;
  bit [N-1:0] m_hs = '0;
  int         cyc_n = 0;

  always @(posedge clk) begin
    cyc_n++;
    m_hs = '0;
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_gnt = N - 1; m_starve = 0;
      m_err_to = 1'b0; m_err_src = 0;
    end else if (m_ok) begin
      m_err_to = 1'b0;
      if (!m_busy) begin
        if (arb_en && (req_valid != '0)) begin
          for (int k = 1; k <= N; k++) begin
            if (!m_busy && req_valid[(m_gnt + k) % N]) begin
              m_gnt  = (m_gnt + k) % N;
              m_busy = 1'b1;
            end
          end
          m_starve = 0;
        end
      end else if (req_valid[m_gnt] && tx_ready) begin
        m_hs[m_gnt] = 1'b1;
        m_starve = 0;
        if (req_last[m_gnt]) m_busy = 1'b0;
      end else if (!req_valid[m_gnt]) begin
        m_starve++;
        if (m_starve == TO) begin
          m_busy = 1'b0; m_err_to = 1'b1; m_err_src = m_gnt; m_starve = 0;
        end
      end
    end
  end

  logic [7:0] obs_d [$];
  int         obs_g [$];
  int         obs_c [$];
  int         err_cnt = 0;
  int         err_cyc = -1;

  always @(negedge clk) begin
    logic       exp_tv;
    logic [N-1:0] exp_rdy;
    if (m_ok) begin
      exp_tv  = rst_n && m_busy && req_valid[m_gnt];
      exp_rdy = '0;
      if (rst_n && m_busy && tx_ready) exp_rdy[m_gnt] = 1'b1;
      chk("tx_valid", 32'(tx_valid), 32'(exp_tv));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
      chk("err_to", 32'(err_to), 32'(m_err_to));
      chk("err_src", 32'(err_src), 32'(m_err_src));
      if (exp_tv) chk("tx_data", 32'(tx_data), 32'(req_data[m_gnt]));
      if (tx_valid === 1'b1 && tx_ready && rst_n) begin
        obs_d.push_back(tx_data);
        obs_g.push_back(int'(gnt_id));
        obs_c.push_back(cyc_n);
      end
      if (err_to === 1'b1) begin
        err_cnt++;
        err_cyc = cyc_n;
      end
    end
  end

  task automatic push(input int i, input logic [7:0] d, input bit last);
    bd[i][tail[i] % BUF] = d;
    bl[i][tail[i] % BUF] = last;
    tail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = !hold_off[i] && (drop_cnt[i] == 0);
        req_data[i]  = bd[i][head[i] % BUF];
        req_last[i]  = bl[i][head[i] % BUF];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (m_hs[i]) head[i]++;
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); cyc(); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; drop_cnt[i] = 0; hold_off[i] = 1'b0;
    end
    arb_en = 1'b1; tx_ready = 1'b1;
    drive(); cyc(); cyc();
    rst_n = 1'b1;
    obs_d.delete(); obs_g.delete(); obs_c.delete();
  endtask

  int hs_cyc;
  int e0;

  initial begin
    rst_n = 1'b0; arb_en = 1'b0; tx_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd3);
    chk("rst_err_to", 32'(err_to), 32'd0);
    chk("rst_err_src", 32'(err_src), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);

    // Two 3-byte packets from requesters 0 and 2, separated by one idle bubble.
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    push(2, 8'h61, 0); push(2, 8'h62, 0); push(2, 8'h63, 1);
    run(15);
    chk("s1_count", obs_d.size(), 6);
    if (obs_d.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("s1_data", 32'(obs_d[k]), (k < 3) ? 32'h41 + k : 32'h61 + k - 3);
        chk("s1_gnt", 32'(obs_g[k]), (k < 3) ? 32'd0 : 32'd2);
      end
      chk("s1_bubble", 32'(obs_c[3] - obs_c[2]), 32'd2);
    end

    // Every requester always holding a 1-byte packet: strict rotation, one byte every other cycle.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) push(i, 8'(8'h20 + p * 4 + i), 1);
    run(30);
    chk("s2_count", obs_d.size(), 12);
    if (obs_d.size() == 12) begin
      for (int k = 0; k < 12; k++) chk("s2_order", 32'(obs_g[k]), 32'(k % 4));
      for (int k = 1; k < 12; k++) chk("s2_spacing", 32'(obs_c[k] - obs_c[k-1]), 32'd2);
    end

    // Requester 1 stalls after its first byte and is aborted; requester 3 goes next.
    do_reset();
    push(1, 8'h10, 0); push(1, 8'h11, 1);
    push(3, 8'h30, 1);
    e0 = err_cnt; hs_cyc = -1; err_cyc = -1;
    for (int t = 0; t < 10 && hs_cyc < 0; t++) begin
      drive(); cyc();
      if (m_hs[1]) begin hs_cyc = cyc_n; hold_off[1] = 1'b1; end
    end
    run(20);
    chk("s3_to_delay", 32'(err_cyc - hs_cyc), 32'd8);
    chk("s3_err_src", 32'(err_src), 32'd1);
    chk("s3_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("s3_count", obs_d.size(), 2);
    if (obs_d.size() == 2) begin
      chk("s3_byte0", 32'(obs_d[0]), 32'h10);
      chk("s3_next_data", 32'(obs_d[1]), 32'h30);
      chk("s3_next_gnt", 32'(obs_g[1]), 32'd3);
    end

    // Long backpressure is not a timeout.
    do_reset();
    push(0, 8'h55, 1);
    tx_ready = 1'b0;
    e0 = err_cnt;
    run(5000);
    chk("s4_no_err", 32'(err_cnt - e0), 32'd0);
    chk("s4_held", obs_d.size(), 0);
    chk("s4_busy_held", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    run(4);
    chk("s4_count", obs_d.size(), 1);
    if (obs_d.size() == 1) chk("s4_data", 32'(obs_d[0]), 32'h55);

    // Disabling arbitration mid-packet lets the packet finish but blocks the next grant.
    do_reset();
    for (int k = 0; k < 4; k++) push(2, 8'(8'hA0 + k), k == 3);
    run(2);
    arb_en = 1'b0;
    push(0, 8'hB0, 1);
    run(12);
    chk("s5_count", obs_d.size(), 4);
    if (obs_d.size() == 4)
      for (int k = 0; k < 4; k++) chk("s5_data", 32'(obs_d[k]), 32'hA0 + k);
    chk("s5_no_grant", 32'(busy), 32'd0);
    chk("s5_gnt_kept", 32'(gnt_id), 32'd2);
    arb_en = 1'b1;
    drive(); cyc();
    chk("s5_regrant_busy", 32'(busy), 32'd1);
    chk("s5_regrant_gnt", 32'(gnt_id), 32'd0);
    run(4);

    // One-cycle reset during byte 2 of a requester 3 packet.
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 8'(8'hD0 + k), k == 3);
    run(2);
    e0 = err_cnt;
    rst_n = 1'b0;
    drive();
    #2;
    chk("s6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("s6_rst_req_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_tx_valid", 32'(tx_valid), 32'd0);
    chk("s6_err_to", 32'(err_to), 32'd0);
    chk("s6_gnt_id", 32'(gnt_id), 32'd3);
    rst_n = 1'b1;
    run(3);
    chk("s6_no_err", 32'(err_cnt - e0), 32'd0);

    // Random traffic with backpressure, gaps long enough to time out, and rare resets.
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      arb_en   = ($urandom_range(0, 15) != 0);
      rst_n    = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) begin
        if (drop_cnt[i] > 0) drop_cnt[i]--;
        else if ($urandom_range(0, 29) == 0) drop_cnt[i] = $urandom_range(1, 12);
        if ((tail[i] - head[i]) < 3 && $urandom_range(0, 7) == 0) begin
          automatic int len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) push(i, 8'($urandom_range(0, 255)), k == len - 1);
        end
      end
      drive(); cyc();
    end
    rst_n = 1'b1;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (0=ADC1, 1=ADC2, 2=DAC1, 3=DAC2).
REQ-002 The block SHALL have parameter TO_CYC, default 1000, giving the stall-timeout length in clk cycles (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with one clock for the whole block.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port arb_en, input, 1 bit: enables new grants.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester byte valid.
REQ-007 The block SHALL have port req_data, input, NUM_REQ x 8 bits: per-requester byte.
REQ-008 The block SHALL have port req_last, input, NUM_REQ bits: marks the last byte of a packet.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester byte accepted.
REQ-010 The block SHALL have port tx_valid, output, 1 bit: byte valid towards the UART TX.
REQ-011 The block SHALL have port tx_data, output, 8 bits: byte towards the UART TX.
REQ-012 The block SHALL have port tx_ready, input, 1 bit: UART TX accepts the byte.
REQ-013 The block SHALL have port busy, output, 1 bit: a packet is in progress.
REQ-014 The block SHALL have port gnt_id, output, clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-015 The block SHALL have port err_to, output, 1 bit: one-cycle timeout-abort pulse.
REQ-016 The block SHALL have port err_src, output, clog2(NUM_REQ) bits: requester index that caused err_to; it is held until the next err_to.

Function
REQ-017 The FSM SHALL have two states: IDLE and XFER.
REQ-018 In IDLE with arb_en=1 and any req_valid set, the block SHALL register a grant on the next edge, moving to XFER with gnt_id set to the winner.
REQ-019 Arbitration SHALL be round-robin: search starts at (gnt_id+1) mod NUM_REQ and wraps, so the winner is the first requester with req_valid set.
REQ-020 The grant SHALL be packet-locked: while in XFER no other requester is granted, regardless of its req_valid.
REQ-021 In XFER, tx_valid SHALL equal req_valid[gnt_id], tx_data SHALL equal req_data[gnt_id], and req_ready[gnt_id] SHALL equal tx_ready; these are combinational.
REQ-022 All non-granted req_ready bits SHALL be 0.
REQ-023 In IDLE, tx_valid=0 and req_ready=0.
REQ-024 A handshake is tx_valid&tx_ready; a handshake with req_last[gnt_id]=1 SHALL return the FSM to IDLE on the next edge.
REQ-025 Consequently there SHALL be exactly one IDLE bubble cycle between packets, and a 1-byte packet occupies XFER for one cycle when tx_ready=1.
REQ-026 busy SHALL be 1 exactly while in XFER.
REQ-027 arb_en=0 SHALL only block the IDLE->XFER transition; a packet already in XFER runs to completion.
REQ-028 Stall counter, 16 bits: zeroed on entry to XFER and on every handshake; incremented each XFER cycle with req_valid[gnt_id]=0; held (not incremented) when req_valid=1 and tx_ready=0, because a downstream backpressure stall is never a timeout.
REQ-029 When the stall counter reaches TO_CYC-1 and is incremented again, the block SHALL, on that edge, go to IDLE, pulse err_to for one cycle, and load err_src with gnt_id.
REQ-030 No byte SHALL be emitted for the aborted requester after the abort.
REQ-031 If the aborted requester later raises req_valid, it SHALL be treated as a new packet under normal round-robin.
REQ-032 gnt_id SHALL keep its value in IDLE so that the round-robin pointer persists.
REQ-033 If a requester drops req_valid mid-packet and re-raises it before the timeout, the packet SHALL continue and the counter SHALL clear on the next handshake.

Reset
REQ-034 On a clk edge with rst_n=0, the block SHALL enter IDLE with gnt_id=NUM_REQ-1 (so requester 0 wins first), stall counter=0, err_to=0, err_src=0, and busy=0.
REQ-035 During reset, tx_valid and req_ready SHALL be 0.
REQ-036 Reset asserted mid-packet SHALL abort the packet without raising err_to.

Verification
REQ-037 Scenario 1: after reset, req 0 and req 2 both valid with 3-byte packets (0x41,0x42,0x43 / 0x61,0x62,0x63), tx_ready=1 -> tx shows 41,42,43, then one idle cycle, then 61,62,63; gnt_id goes 0 then 2.
REQ-038 Scenario 2: all 4 requesters hold 1-byte packets continuously -> grant order 0,1,2,3,0,... with tx_valid high every other cycle.
REQ-039 Scenario 3: req 1 sends byte 0x10 (last=0), then drops req_valid; TO_CYC=8 -> err_to pulses exactly 8 cycles after the handshake, err_src=1, FSM returns to IDLE, and req 3 (pending) is granted next.
REQ-040 Scenario 4: granted req 0 with valid=1 and tx_ready held 0 for 5000 cycles (TO_CYC=8) -> no err_to; the byte transfers when tx_ready rises.
REQ-041 Scenario 5: arb_en deasserted mid-packet on req 2 -> the packet completes, no new grant occurs while arb_en=0 even with req 0 valid, and req 0 is granted one cycle after arb_en=1.
REQ-042 Scenario 6: rst_n=0 for one cycle during byte 2 of a req 3 packet -> next cycle busy=0, tx_valid=0, err_to=0, gnt_id=NUM_REQ-1.
